// File: rtl/uart_hash_ctrl.sv
// Frame controller between a UART receiver/transmitter pair and a hash core.
// Collects a length-prefixed frame into a byte buffer, streams it into the
// hash core, then returns the digest MSB byte first. Bad lengths and
// inter-byte timeouts are answered with a single error byte.
module uart_hash_ctrl #(
    parameter int         MAX_LEN        = 64,
    parameter int         DIGEST_BYTES   = 4,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] ERR_CODE       = 8'hEE
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,      // asynchronous, active-low
    input  logic [7:0]                i_rx_data,
    input  logic                      i_rx_ready,
    output logic [7:0]                o_tx_data,
    output logic                      o_tx_send,
    input  logic                      i_tx_busy,
    output logic                      o_hash_start,
    output logic [7:0]                o_hash_data,
    output logic                      o_hash_valid,
    output logic                      o_hash_last,
    input  logic                      i_hash_ready,
    input  logic                      i_hash_done,
    input  logic [DIGEST_BYTES*8-1:0] i_hash_digest,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int DW     = DIGEST_BYTES * 8;
    localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [TW-1:0] TLIM  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAXL  = 8'(MAX_LEN);
    localparam logic [7:0]    KLAST = 8'(DIGEST_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PAYLOAD,
        S_HSTART,
        S_FEED,
        S_WAIT,
        S_TX_SEND,
        S_TX_GUARD,
        S_TX_WAIT,
        S_ERR
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [7:0]      r_len;
    logic [7:0]      r_widx;
    logic [7:0]      r_ridx;
    logic [TW-1:0]   r_tcnt;
    logic [DW-1:0]   r_digest;       // shifted left as bytes go out
    logic [7:0]      r_k;
    logic            r_err_mode;     // transmitting ERR_CODE instead of digest
    logic [7:0]      r_mem [0:MAX_LEN-1];
    logic [7:0]      r_rd_data;

    logic            w_rx_wr;
    logic            w_last_rd;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [7:0]      w_tx_byte;

    assign w_rx_wr   = (r_state == S_PAYLOAD) && i_rx_ready;
    assign w_last_rd = (r_ridx == r_len - 8'd1);
    assign w_tx_byte = r_err_mode ? ERR_CODE : r_digest[DW-1 -: 8];

    // Read address runs one step ahead on a handshake so the registered read
    // presents the next byte exactly when the core wants it.
    always_comb begin
        w_rd_addr = r_ridx[ADDR_W-1:0];
        if (r_state == S_HSTART) begin
            w_rd_addr = '0;
        end else if ((r_state == S_FEED) && i_hash_ready) begin
            w_rd_addr = r_ridx[ADDR_W-1:0] + ADDR_W'(1);
        end
    end

    // Payload buffer: write on received payload bytes, registered read; not reset.
    always_ff @(posedge i_clk) begin
        if (w_rx_wr) begin
            r_mem[r_widx[ADDR_W-1:0]] <= i_rx_data;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_ready) begin
                    if ((i_rx_data == 8'd0) || (i_rx_data > MAXL)) begin
                        w_state_next = S_ERR;
                    end else begin
                        w_state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_ready) begin
                    if (r_widx == r_len - 8'd1) begin
                        w_state_next = S_HSTART;
                    end
                end else if (r_tcnt == TLIM) begin
                    w_state_next = S_ERR;
                end
            end
            S_HSTART:   w_state_next = S_FEED;
            S_FEED: begin
                if (i_hash_ready && w_last_rd) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_hash_done) begin
                    w_state_next = S_TX_SEND;
                end
            end
            S_TX_SEND: begin
                if (!i_tx_busy) begin
                    w_state_next = S_TX_GUARD;
                end
            end
            S_TX_GUARD: w_state_next = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!i_tx_busy) begin
                    w_state_next = (r_k == KLAST) ? S_IDLE : S_TX_SEND;
                end
            end
            S_ERR:      w_state_next = S_TX_SEND;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // State register plus indices, timeout counter and digest shifter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= 8'd0;
            r_widx     <= 8'd0;
            r_ridx     <= 8'd0;
            r_tcnt     <= '0;
            r_digest   <= '0;
            r_k        <= 8'd0;
            r_err_mode <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    r_widx <= 8'd0;
                    r_tcnt <= '0;
                    if (i_rx_ready) begin
                        r_len <= i_rx_data;
                    end
                end
                S_PAYLOAD: begin
                    if (i_rx_ready) begin
                        r_widx <= r_widx + 8'd1;
                        r_tcnt <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_HSTART: r_ridx <= 8'd0;
                S_FEED: begin
                    if (i_hash_ready) begin
                        r_ridx <= r_ridx + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (i_hash_done) begin
                        r_digest   <= i_hash_digest;
                        r_k        <= 8'd0;
                        r_err_mode <= 1'b0;
                    end
                end
                S_ERR: begin
                    // One-byte reply: start the byte counter at its last value.
                    r_k        <= KLAST;
                    r_err_mode <= 1'b1;
                end
                S_TX_WAIT: begin
                    if (!i_tx_busy && (r_k != KLAST)) begin
                        r_k      <= r_k + 8'd1;
                        r_digest <= r_digest << 8;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore-style outputs decoded from state so reset clears them at once.
    always_comb begin
        o_tx_send    = 1'b0;
        o_tx_data    = 8'd0;
        o_hash_start = 1'b0;
        o_hash_data  = 8'd0;
        o_hash_valid = 1'b0;
        o_hash_last  = 1'b0;
        o_err        = 1'b0;
        o_busy       = (r_state != S_IDLE);
        case (r_state)
            S_HSTART: o_hash_start = 1'b1;
            S_FEED: begin
                o_hash_valid = 1'b1;
                o_hash_data  = r_rd_data;
                o_hash_last  = w_last_rd;
            end
            S_TX_SEND: begin
                o_tx_data = w_tx_byte;
                o_tx_send = !i_tx_busy;
            end
            S_ERR:    o_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_hash_ctrl.sv
// Bench for uart_hash_ctrl: table of frames plus randomized frames, checked
// against a frame-level model (expected hash stream = payload, expected tx =
// digest bytes MSB first or a single error byte), and hand-written sequences
// for latency, timeout and reset corner cases.
module tb_uart_hash_ctrl;

    localparam int         MAXL = 8;
    localparam int         DB   = 4;
    localparam int         TOUT = 50;
    localparam logic [7:0] EC   = 8'hEE;
    localparam int         NV   = 24;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_busy;
    logic        hash_start;
    logic [7:0]  hash_data;
    logic        hash_valid;
    logic        hash_last;
    logic        hash_ready;
    logic        hash_done;
    logic [31:0] hash_digest;
    logic        busy;
    logic        err;

    uart_hash_ctrl #(
        .MAX_LEN(MAXL), .DIGEST_BYTES(DB), .TIMEOUT_CYCLES(TOUT), .ERR_CODE(EC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(rx_data), .i_rx_ready(rx_ready),
        .o_tx_data(tx_data), .o_tx_send(tx_send), .i_tx_busy(tx_busy),
        .o_hash_start(hash_start), .o_hash_data(hash_data),
        .o_hash_valid(hash_valid), .o_hash_last(hash_last),
        .i_hash_ready(hash_ready), .i_hash_done(hash_done),
        .i_hash_digest(hash_digest),
        .o_busy(busy), .o_err(err)
    );

    typedef struct {
        logic [7:0]  len;
        int          mode;    // 0 ready high, 1 toggling, 2 random, 3 held low
        bit          hold;    // hold tx_busy for 100 cycles around digest send
        int          extra;   // stray rx bytes during WAIT/TX
        logic [31:0] dig;
        bit          abc;     // payload 0x61,0x62,...
    } vec_t;

    vec_t        tbl [NV];
    logic [7:0]  pay [$];
    logic [8:0]  got_hash [$];
    logic [7:0]  got_tx [$];
    int          n_hstart, n_err, n_send_busy, n_unstable;
    bit          got_last;
    int          ready_mode;
    bit          force_busy;
    bit          tx_start_req;
    int          n_vec, n_miss;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1);
    end

    // Hash core ready pattern.
    initial begin
        hash_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       hash_ready = 1'b1;
                1:       hash_ready = ~hash_ready;
                2:       hash_ready = 1'($urandom_range(0, 1));
                default: hash_ready = 1'b0;
            endcase
        end
    end

    // Transmitter model: busy for 10 cycles after each accepted send.
    initial begin
        int cnt;
        cnt = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tx_start_req) begin
                cnt = 10;
                tx_start_req = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
            end
            tx_busy = (cnt > 0) || force_busy;
        end
    end

    // Observer of DUT outputs, sampled mid-cycle.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_data;
        logic       prev_last;
        prev_hold = 1'b0;
        prev_data = 8'd0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold && !(hash_valid && hash_data == prev_data && hash_last == prev_last))
                    n_unstable++;
                prev_hold = hash_valid && !hash_ready;
                prev_data = hash_data;
                prev_last = hash_last;
                if (hash_start) n_hstart++;
                if (hash_valid && hash_ready) begin
                    got_hash.push_back({hash_last, hash_data});
                    if (hash_last) got_last = 1'b1;
                end
                if (tx_send) begin
                    got_tx.push_back(tx_data);
                    if (tx_busy) n_send_busy++;
                    tx_start_req = 1'b1;
                end
                if (err) n_err++;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {42'd0, tx_send, tx_data, hash_start, hash_data, hash_valid, hash_last, busy, err};
    endfunction

    task automatic clear_mon();
        got_hash.delete();
        got_tx.delete();
        n_hstart    = 0;
        n_err       = 0;
        n_send_busy = 0;
        n_unstable  = 0;
        got_last    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic pulse_done(input logic [31:0] d);
        @(posedge clk); #1;
        hash_digest = d;
        hash_done   = 1'b1;
        @(posedge clk); #1;
        hash_done   = 1'b0;
        hash_digest = ~d;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("return_to_idle", busy, 0);
        repeat (15) @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input vec_t v);
        bit bad;
        int t;
        bad = (v.len == 8'd0) || (v.len > 8'(MAXL));
        clear_mon();
        ready_mode = v.mode;
        pay.delete();
        if (!bad)
            for (int i = 0; i < int'(v.len); i++)
                pay.push_back(v.abc ? 8'(8'h61 + i) : 8'($urandom));
        if (v.extra > 0) pulse_done(32'($urandom));   // stray done in IDLE
        send_byte(v.len, $urandom_range(0, 3));
        foreach (pay[i]) send_byte(pay[i], $urandom_range(0, 3));
        if (!bad) begin
            t = 0;
            while (!got_last && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("last_handshake_seen", got_last, 1);
            for (int i = 0; i < v.extra; i++) send_byte(8'($urandom), 0);
            if (v.hold) force_busy = 1'b1;
            pulse_done(v.dig);
            if (v.hold) begin
                for (int i = 0; i < v.extra; i++) send_byte(8'($urandom), 0);
                repeat (100) @(posedge clk);
                #1;
                force_busy = 1'b0;
            end
        end
        wait_idle();
        check("hstart_count", n_hstart, bad ? 0 : 1);
        check("hash_count", got_hash.size(), pay.size());
        for (int i = 0; i < pay.size() && i < got_hash.size(); i++)
            check("hash_byte", got_hash[i], {(i == pay.size() - 1), pay[i]});
        check("tx_count", got_tx.size(), bad ? 1 : DB);
        for (int i = 0; i < got_tx.size() && i < DB; i++)
            check("tx_byte", got_tx[i], bad ? EC : 8'(v.dig >> (8 * (DB - 1 - i))));
        check("err_count", n_err, bad ? 1 : 0);
        check("send_while_busy", n_send_busy, 0);
        check("hash_unstable", n_unstable, 0);
        $display("frame len=%0d mode=%0d hold=%0d extra=%0d hashed=%0d tx=%0d err=%0d",
                 v.len, v.mode, v.hold, v.extra, got_hash.size(), got_tx.size(), n_err);
    endtask

    initial begin
        int t;
        n_vec = 0; n_miss = 0;
        rst_n = 1'b0; rx_data = 8'd0; rx_ready = 1'b0;
        hash_done = 1'b0; hash_digest = 32'd0;
        ready_mode = 0; force_busy = 1'b0; tx_start_req = 1'b0;
        clear_mon();

        tbl[0] = '{8'd3, 0, 1'b0, 0, 32'hDEADBEEF, 1'b1};
        tbl[1] = '{8'd3, 1, 1'b0, 0, 32'hDEADBEEF, 1'b1};
        tbl[2] = '{8'd0, 0, 1'b0, 0, 32'h0, 1'b0};
        tbl[3] = '{8'(MAXL + 1), 0, 1'b0, 0, 32'h0, 1'b0};
        tbl[4] = '{8'(MAXL), 2, 1'b0, 1, 32'hCAFEF00D, 1'b0};
        tbl[5] = '{8'd1, 0, 1'b0, 0, 32'h01020304, 1'b0};
        tbl[6] = '{8'd5, 2, 1'b1, 3, 32'h89ABCDEF, 1'b0};
        for (int i = 7; i < NV; i++) begin
            tbl[i].len   = 8'($urandom_range(0, MAXL + 1));
            tbl[i].mode  = $urandom_range(0, 2);
            tbl[i].hold  = ($urandom_range(0, 5) == 0);
            tbl[i].extra = $urandom_range(0, 2);
            tbl[i].dig   = $urandom;
            tbl[i].abc   = 1'b0;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Latency: hash_start, first hash_valid, first tx_send.
        clear_mon();
        ready_mode = 0;
        send_byte(8'd2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        @(negedge clk);
        check("hstart_latency", hash_start, 1);
        @(negedge clk);
        check("first_hash_byte", {hash_valid, hash_last, hash_data}, {2'b10, 8'hAA});
        @(negedge clk);
        check("last_hash_byte", {hash_valid, hash_last, hash_data}, {2'b11, 8'h55});
        pulse_done(32'h12345678);
        @(negedge clk);
        check("tx_send_latency", {tx_send, tx_data}, {1'b1, 8'h12});
        wait_idle();
        check("lat_tx_count", got_tx.size(), 4);
        if (got_tx.size() == 4)
            check("lat_tx_bytes", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h12345678);
        $display("latency sequence tx=%0d", got_tx.size());

        // Invalid length: err then ERR_CODE send on consecutive cycles.
        clear_mon();
        send_byte(8'd0, 0);
        @(negedge clk);
        check("err_latency", {err, tx_send}, 2'b10);
        @(negedge clk);
        check("err_tx_latency", {err, tx_send, tx_data}, {2'b01, EC});
        wait_idle();
        check("err_hstart", n_hstart, 0);
        $display("invalid length sequence err=%0d tx=%0d", n_err, got_tx.size());

        // Table and randomized frames.
        for (int i = 0; i < NV; i++) do_frame(tbl[i]);

        // Inter-byte timeout, then recovery.
        clear_mon();
        send_byte(8'd4, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        t = 0;
        while (!err && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("timeout_window", (t >= TOUT - 2) && (t <= TOUT + 4), 1);
        wait_idle();
        check("timeout_tx_count", got_tx.size(), 1);
        if (got_tx.size() == 1) check("timeout_tx_byte", got_tx[0], EC);
        check("timeout_hstart", n_hstart, 0);
        $display("timeout sequence cycles=%0d tx=%0d", t, got_tx.size());
        do_frame(tbl[0]);

        // Reset mid-PAYLOAD.
        clear_mon();
        send_byte(8'd5, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_payload_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("rst_payload_no_tx", got_tx.size() + n_err, 0);
        check("rst_payload_idle", busy, 0);
        $display("reset mid-payload tx=%0d", got_tx.size());
        do_frame(tbl[4]);

        // Reset mid-FEED with the core stalled.
        clear_mon();
        ready_mode = 3;
        send_byte(8'd4, 0);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        t = 0;
        while (!hash_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("feed_reached", hash_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_feed_outputs", outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        check("rst_feed_no_tx", got_tx.size() + n_err, 0);
        check("rst_feed_idle", busy, 0);
        $display("reset mid-feed tx=%0d", got_tx.size());
        do_frame(tbl[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
